// File: rtl/pwq_pkg.sv
// Shared types and constants for the pending write queue.
//   pending_write_t : one committed store {addr, data, size}
//   SIZE_B/H/W/D    : one-hot byte-count encodings for 1/2/4/8-byte stores
//   pwq_state_e     : queue mode, RUN (accepting stores) or DRAIN (ecall waiting)
//   normalise_size  : maps any non-one-hot size to an 8-byte write
//   size_bytes      : byte count of a normalised size
package pwq_pkg;

    localparam int PWQ_ADDR_WIDTH = 64;
    localparam int PWQ_DATA_WIDTH = 64;
    localparam int PWQ_SIZE_WIDTH = 4;

    localparam logic [PWQ_SIZE_WIDTH-1:0] SIZE_B = 4'b0001;
    localparam logic [PWQ_SIZE_WIDTH-1:0] SIZE_H = 4'b0010;
    localparam logic [PWQ_SIZE_WIDTH-1:0] SIZE_W = 4'b0100;
    localparam logic [PWQ_SIZE_WIDTH-1:0] SIZE_D = 4'b1000;

    typedef struct packed {
        logic [PWQ_ADDR_WIDTH-1:0] addr;
        logic [PWQ_DATA_WIDTH-1:0] data;
        logic [PWQ_SIZE_WIDTH-1:0] size;
    } pending_write_t;

    typedef enum logic {
        PWQ_RUN,
        PWQ_DRAIN
    } pwq_state_e;

    function automatic logic [PWQ_SIZE_WIDTH-1:0] normalise_size(
        input logic [PWQ_SIZE_WIDTH-1:0] size
    );
        case (size)
            SIZE_B, SIZE_H, SIZE_W, SIZE_D: return size;
            default:                        return SIZE_D;
        endcase
    endfunction

    function automatic logic [PWQ_ADDR_WIDTH-1:0] size_bytes(
        input logic [PWQ_SIZE_WIDTH-1:0] size
    );
        case (size)
            SIZE_B:  return 64'd1;
            SIZE_H:  return 64'd2;
            SIZE_W:  return 64'd4;
            default: return 64'd8;
        endcase
    endfunction

endpackage

// File: rtl/pwq_fwd_match.sv
// Store-to-load forwarding search over the live queue entries.
// Only instantiated when PWQ_FWD_EN is defined.
//   entries/rd_ptr/count : queue storage and its live window
//   ld_valid/ld_addr     : load probing the 8-byte block containing ld_addr
//   hit/data             : youngest overlapping store is an aligned 8-byte store
//   conflict             : youngest overlapping store only covers part of the block
module pwq_fwd_match
    import pwq_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  pending_write_t              entries [DEPTH],
    input  logic [$clog2(DEPTH)-1:0]    rd_ptr,
    input  logic [$clog2(DEPTH):0]      count,
    input  logic                        ld_valid,
    input  logic [PWQ_ADDR_WIDTH-1:0]   ld_addr,
    output logic                        hit,
    output logic [PWQ_DATA_WIDTH-1:0]   data,
    output logic                        conflict
);

    localparam int PTR_W = $clog2(DEPTH);

    // The load always covers its whole aligned block, so its offset is irrelevant.
    logic unused_ld_offset;
    assign unused_ld_offset = ^ld_addr[2:0];

    // Walk oldest to youngest so a younger overlapping store overrides older ones.
    always_comb begin
        pending_write_t            e;
        logic [PTR_W-1:0]          idx;
        logic [PWQ_ADDR_WIDTH-1:0] last_blk;
        logic [PWQ_ADDR_WIDTH-1:0] ld_blk;
        logic                      exact;
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        hit      = 1'b0;
        conflict = 1'b0;
        data     = '0;
        e        = '0;
        idx      = '0;
        last_blk = '0;
        exact    = 1'b0;
        ld_blk   = {3'b000, ld_addr[PWQ_ADDR_WIDTH-1:3]};
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PTR_W'(k);
            e   = entries[idx];
            // A misaligned store may spill into the next block; test both ends.
            last_blk = (e.addr + size_bytes(e.size) - 64'd1) >> 3;
            if (ld_valid && (k < int'(count)) &&
                ((e.addr[PWQ_ADDR_WIDTH-1:3] == ld_addr[PWQ_ADDR_WIDTH-1:3]) ||
                 (last_blk == ld_blk))) begin
                exact    = (e.size == SIZE_D) && (e.addr[2:0] == 3'b000);
                hit      = exact;
                conflict = !exact;
                data     = exact ? e.data : '0;
            end
        end
    end

endmodule

// File: rtl/pending_write_queue.sv
// Store-commit FIFO between the memory stage and writeback.
// Optional feature macro: PWQ_FWD_EN (adds the load forwarding probe ports).
//   in_push_*                 : committed store offered by the memory stage
//   out_push_ready            : store accepted on a valid && ready edge
//   in_stall_from_icache/dcache : suppress the head pop while either is high
//   in_drain_req              : ecall pending; block pushes and report drained
//   out_*_pending_write       : head entry that writeback performs this edge
//   out_count                 : occupancy
//   out_drained               : in drain mode with nothing left to write
//   in_ld_* / out_ld_*        : (PWQ_FWD_EN) forwarding probe for a load
module pending_write_queue
    import pwq_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        in_push_valid,
    input  logic [PWQ_ADDR_WIDTH-1:0]   in_push_addr,
    input  logic [PWQ_DATA_WIDTH-1:0]   in_push_data,
    input  logic [PWQ_SIZE_WIDTH-1:0]   in_push_size,
    output logic                        out_push_ready,
    input  logic                        in_stall_from_icache,
    input  logic                        in_stall_from_dcache,
    input  logic                        in_drain_req,
    output logic                        out_do_pending_write,
    output logic [PWQ_ADDR_WIDTH-1:0]   out_address_pending_write,
    output logic [PWQ_DATA_WIDTH-1:0]   out_data_pending_write,
    output logic [PWQ_SIZE_WIDTH-1:0]   out_size_pending_write,
    output logic [$clog2(DEPTH):0]      out_count,
    output logic                        out_drained
`ifdef PWQ_FWD_EN
    ,
    input  logic                        in_ld_valid,
    input  logic [PWQ_ADDR_WIDTH-1:0]   in_ld_addr,
    output logic                        out_ld_hit,
    output logic [PWQ_DATA_WIDTH-1:0]   out_ld_data,
    output logic                        out_ld_conflict
`endif
);

    localparam int                PTR_W      = $clog2(DEPTH);
    localparam logic [PTR_W:0]    FULL_COUNT = (PTR_W + 1)'(DEPTH);

    pending_write_t   mem_q [DEPTH];
    pending_write_t   mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    pwq_state_e       state_q, state_d;
    logic             push, pop;

    // ---------------- FSM: state register ----------------
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= PWQ_RUN;
        else          state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            PWQ_RUN:   if (in_drain_req)  state_d = PWQ_DRAIN;
            PWQ_DRAIN: if (!in_drain_req) state_d = PWQ_RUN;
            default:                      state_d = PWQ_RUN;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Ready looks only at registered state: a full queue popping this edge is still not ready.
    always_comb begin
        out_push_ready = (count_q != FULL_COUNT) && (state_q == PWQ_RUN);
        out_drained    = (state_q == PWQ_DRAIN) && (count_q == '0);
    end

    // ---------------- Head presentation ----------------
    // Stale slots are masked so an empty queue presents all-zero head fields.
    always_comb begin
        out_do_pending_write      = (count_q != '0);
        out_address_pending_write = out_do_pending_write ? mem_q[rd_ptr_q].addr : '0;
        out_data_pending_write    = out_do_pending_write ? mem_q[rd_ptr_q].data : '0;
        out_size_pending_write    = out_do_pending_write ? mem_q[rd_ptr_q].size : '0;
        out_count                 = count_q;
    end

    assign push = in_push_valid && out_push_ready;
    assign pop  = out_do_pending_write && !in_stall_from_icache && !in_stall_from_dcache;

    // ---------------- Queue next state ----------------
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q].addr = in_push_addr;
            mem_d[wr_ptr_q].data = in_push_data;
            mem_d[wr_ptr_q].size = normalise_size(in_push_size);
            wr_ptr_d             = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; count/pointers define which slots are live.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

`ifdef PWQ_FWD_EN
    pwq_fwd_match #(.DEPTH(DEPTH)) u_fwd_match (
        .entries  (mem_q),
        .rd_ptr   (rd_ptr_q),
        .count    (count_q),
        .ld_valid (in_ld_valid),
        .ld_addr  (in_ld_addr),
        .hit      (out_ld_hit),
        .data     (out_ld_data),
        .conflict (out_ld_conflict)
    );
`endif

endmodule
